// File: rtl/serial_sub_if.sv
// serial_sub_if: operand/result bundle for the bit-serial subtractor.
//
// Handshake: start is a request that the slave samples only while it is
// not busy (IDLE or DONE). a, b and bin are captured on that edge and may
// change freely afterwards. busy is high while the subtraction runs. done
// is a one-cycle pulse marking diff/bout/ovf valid. busy and done are never
// high together. Results hold until the next completion.
//
// Signals:
//   start     master -> slave  operation request
//   a, b      master -> slave  minuend, subtrahend (WIDTH bits)
//   bin       master -> slave  borrow-in
//   busy      slave -> master  computing
//   done      slave -> master  result-valid pulse
//   diff      slave -> master  a - b - bin mod 2^WIDTH
//   bout      slave -> master  unsigned borrow-out
//   ovf       slave -> master  signed overflow
//   dbg_state slave -> master  FSM state for observation (0 IDLE, 1 RUN, 2 DONE)
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic [1:0]       dbg_state;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf, dbg_state
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf, dbg_state
    );
endinterface

// File: rtl/serial_sub.sv
// serial_sub: bit-serial ripple-borrow subtractor, diff = a - b - bin.
// One full-subtractor step per clock, LSB first, using a single borrow flop.
// An accepted start at edge N gives busy over N..N+WIDTH and a done pulse
// from edge N+WIDTH; a start during the done cycle chains straight into
// the next run.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  serial_sub_if slave modport (start/a/b/bin in; busy/done/diff/
//        bout/ovf/dbg_state out)
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    serial_sub_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             ovf_r;

    // One full-subtractor step on the current operand LSBs.
    logic             x;
    logic             y;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        x        = sh_a[0];
        y        = sh_b[0];
        d        = x ^ y ^ br;
        br_next  = (~x & y) | (~(x ^ y) & br);
        // New difference bits enter at the MSB so that after WIDTH steps
        // the first (LSB) bit has arrived at position 0.
        res_next = {d, sh_res[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            sh_res <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            diff_r <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        sh_a   <= bus.a;
                        sh_b   <= bus.b;
                        sh_res <= '0;
                        br     <= bus.bin;
                        cnt    <= '0;
                        // Operand sign bits are kept for the overflow test;
                        // the shift registers lose them during the run.
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    sh_res <= res_next;
                    br     <= br_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff_r <= res_next;
                        bout_r <= br_next;
                        ovf_r  <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.diff      = diff_r;
    assign bus.bout      = bout_r;
    assign bus.ovf       = ovf_r;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: self-checking bench for serial_sub (WIDTH = 8).
module tb_serial_sub;
    localparam int W = 8;

    logic clk;
    logic rst;

    serial_sub_if #(.WIDTH(W)) bus();

    serial_sub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] prev_diff;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // busy and done must never be high together.
    always @(negedge clk) begin
        if (!rst) check("busy_done_exclusive", {30'b0, bus.busy, bus.done}, (bus.busy && bus.done) ? 32'hx : {30'b0, bus.busy, bus.done});
    end

    // Reference model: plain integer arithmetic on the operand values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        int ua, ub, sa, sb, full, sfull;
        logic [31:0] f;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        full = ua - ub - int'(bin);
        f = full;
        d = f[W-1:0];
        bo = (ua < ub + int'(bin));
        sfull = sa - sb - int'(bin);
        ov = (sfull < -(2 ** (W - 1))) || (sfull > (2 ** (W - 1)) - 1);
    endtask

    // ---------------- driver ----------------
    // Issues one operation from IDLE and checks timing and results.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic [W-1:0] ed, input logic eb, input logic eo,
                          input string name);
        int k;
        int busy_cnt;
        bit got;
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.bin = bin;
        bus.start = 1'b1;
        @(posedge clk);
        k = 0;
        busy_cnt = 0;
        got = 0;
        while (!got && k <= W + 4) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus.start = 1'b0;
                bus.a = W'($urandom);
                bus.b = W'($urandom);
                bus.bin = 1'($urandom);
                check({name, "_hold_in_run"}, 32'(bus.diff), 32'(prev_diff));
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) got = 1;
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
        check({name, "_latency"}, k, W + 1);
        check({name, "_busy_cycles"}, busy_cnt, W);
        check({name, "_diff"}, 32'(bus.diff), 32'(ed));
        check({name, "_bout"}, 32'(bus.bout), 32'(eb));
        check({name, "_ovf"}, 32'(bus.ovf), 32'(eo));
        @(negedge clk);
        check({name, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        check({name, "_diff_hold_idle"}, 32'(bus.diff), 32'(ed));
        prev_diff = ed;
    endtask

    // ---------------- test ----------------
    initial begin
        logic [W-1:0] ra, rb, md;
        logic rbin, mb, mo;
        int pulses, last, cyc, seen;

        vecs.push_back('{8'd5,   8'd3,   1'b0, 8'd2,   1'b0, 1'b0});
        vecs.push_back('{8'd2,   8'd4,   1'b1, 8'hFD,  1'b1, 1'b0});
        vecs.push_back('{8'd0,   8'd0,   1'b1, 8'hFF,  1'b1, 1'b0});
        vecs.push_back('{8'd200, 8'd100, 1'b0, 8'd100, 1'b0, 1'b1});
        vecs.push_back('{8'h80,  8'h01,  1'b0, 8'h7F,  1'b0, 1'b1});
        vecs.push_back('{8'h7F,  8'hFF,  1'b0, 8'h80,  1'b1, 1'b1});
        vecs.push_back('{8'hFF,  8'hFF,  1'b1, 8'hFF,  1'b1, 1'b0});
        vecs.push_back('{8'hFF,  8'h00,  1'b0, 8'hFF,  1'b0, 1'b0});

        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;
        prev_diff = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_diff", 32'(bus.diff), 0);
        check("reset_bout", 32'(bus.bout), 0);
        check("reset_ovf",  32'(bus.ovf), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven vectors.
        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].ed, vecs[i].eb, vecs[i].eo,
                   $sformatf("vec%0d", i));

        // Back-to-back operation with start held high.
        @(negedge clk);
        bus.a = 8'd9;
        bus.b = 8'd1;
        bus.bin = 1'b1;
        bus.start = 1'b1;
        pulses = 0;
        last = -1;
        cyc = 0;
        while (pulses < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                check("b2b_diff", 32'(bus.diff), 32'd7);
                if (last >= 0) check("b2b_period", cyc - last, W + 1);
                last = cyc;
                pulses++;
            end
        end
        check("b2b_pulses", pulses, 3);
        bus.start = 1'b0;
        repeat (W + 3) @(negedge clk);
        prev_diff = 8'd7;

        // start during RUN must be ignored and captured operands kept.
        @(negedge clk);
        bus.a = 8'd50;
        bus.b = 8'd20;
        bus.bin = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.a = 8'd1;
        bus.b = 8'd2;
        bus.bin = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        cyc = 0;
        while (!seen && cyc < W + 4) begin
            @(negedge clk);
            cyc++;
            if (bus.done) seen = 1;
        end
        check("ignore_done_seen", seen, 1);
        check("ignore_diff", 32'(bus.diff), 32'd30);
        check("ignore_bout", 32'(bus.bout), 32'd0);
        repeat (W + 3) @(negedge clk);
        check("ignore_no_restart", 32'(bus.busy), 32'd0);
        prev_diff = 8'd30;

        // Reset asserted mid-run aborts with no done pulse.
        @(negedge clk);
        bus.a = 8'd77;
        bus.b = 8'd11;
        bus.bin = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_diff", 32'(bus.diff), 0);
        check("abort_bout", 32'(bus.bout), 0);
        check("abort_ovf",  32'(bus.ovf), 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1;
        end
        check("abort_no_done", seen, 0);
        prev_diff = '0;
        run_op(8'd100, 8'd1, 1'b0, 8'd99, 1'b0, 1'b0, "after_abort");

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rbin = 1'($urandom_range(1, 0));
            model(ra, rb, rbin, md, mb, mo);
            run_op(ra, rb, rbin, md, mb, mo, $sformatf("rand%0d", i));
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Multi-cycle bit-serial ripple-borrow subtractor. Computes diff = a - b - bin, LSB first, one full-subtractor step per clock.
- Counterpart to the combinational ripple-carry adder in the arithmetic library. Uses one borrow flop instead of a WIDTH-deep carry chain.
- Used where area matters more than latency.
- start/busy/done handshake so a controller or bench can sequence operations.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk    input   1      rising-edge clock
rst    input   1      asynchronous, active-high reset
start  input   1      request; sampled only when not busy
a      input   WIDTH  minuend, captured on accepted start
b      input   WIDTH  subtrahend, captured on accepted start
bin    input   1      borrow-in, captured on accepted start
busy   output  1      high while computing
done   output  1      one-cycle pulse, result valid
diff   output  WIDTH  a - b - bin mod 2^WIDTH
bout   output  1      borrow-out (1 when a < b + bin, unsigned)
ovf    output  1      signed two's-complement overflow of a - b - bin

Behaviour:
- Interface decided: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0; internal shift registers, borrow flop and bit counter cleared.
- Reset asserted mid-operation aborts immediately with the same values. No done pulse follows.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at an edge is an accepted start.
  - Load a, b into shift registers and bin into the borrow flop.
  - Set counter=0 and go to RUN.
- RUN: busy=1. Each edge processes the current LSBs x, y with borrow br:
  - d = x ^ y ^ br
  - br' = (~x & y) | (~(x ^ y) & br)
  - d shifts into the result register MSB-side; operand registers shift right; counter increments.
  - After exactly WIDTH RUN edges, go to DONE.
- Transfer to DONE, on the same edge:
  - diff <= assembled result; bout <= final borrow.
  - ovf <= (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
- DONE: done=1, busy=0 for exactly one cycle.
  - start=1 → accepted start, go straight to RUN (back-to-back, no IDLE gap).
  - Otherwise go to IDLE.
- Latency: accepted start at edge N → busy high from N to N+WIDTH; done high from edge N+WIDTH to N+WIDTH+1.
- Throughput: one result per WIDTH+1 cycles.
- start while in RUN is ignored. Captured operands are not disturbed, and a, b, bin may change freely during RUN.
- diff/bout/ovf update only on entry to DONE. They hold through IDLE and through any following RUN until the next completion.
- busy and done are never high together. Both are registered outputs with no combinational path from inputs.
- bin=1 with a=b=0 gives diff = all ones, bout=1 (full wrap-around).

Test Plan:
- Reset, then a=5, b=3, bin=0, start pulse → busy high 8 cycles; done pulse exactly 8 edges after accept; diff=2, bout=0, ovf=0.
- a=2, b=4, bin=1 → diff=8'hFD (253), bout=1, ovf=0.
- a=0, b=0, bin=1 → diff=8'hFF, bout=1. Then a=200, b=100, bin=0 → diff=100, bout=0.
- Signed overflow: a=8'h80, b=8'h01, bin=0 → diff=8'h7F, bout=0, ovf=1.
- Hold start high continuously with a=9, b=1, bin=1 → consecutive done pulses every 9 cycles, each diff=7.
- Within the same run:
  - Change a/b and pulse start at cycle 3 of RUN → ignored; result still from the captured operands.
  - In a separate run, assert rst at cycle 4 → busy=0, done never pulses, diff=0; a fresh start afterwards completes correctly.
